// File: rtl/step_clock_ctrl.sv
// Turns a key-filter Strobe into fixed-width processor clock pulses (single/burst/run); ProcClk rises 1 cycle after Strobe.
// Strobes arriving while Busy are dropped; the STEP_BREAKPOINT_EN macro adds a PC breakpoint that stops burst/run mode.
module step_clock_ctrl #(
    parameter int HIGH_CYCLES = 4,
    parameter int LOW_CYCLES  = 4,
    parameter int DIV_WIDTH   = 24,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Strobe,
    input  logic [1:0]           Mode,
    input  logic [3:0]           Burst,
    input  logic [DIV_WIDTH-1:0] RunDiv,
    input  logic                 Halt,
`ifdef STEP_BREAKPOINT_EN
    input  logic [6:0]           PC,
    input  logic [6:0]           BreakPC,
    input  logic                 BreakEn,
    output logic                 BreakHit,
`endif
    output logic                 ProcClk,
    output logic                 Busy,
    output logic [CNT_WIDTH-1:0] StepCount
);

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_BURST  = 2'b01;
    localparam logic [1:0] MODE_RUN    = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam int PH_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] HI_LAST = PH_W'(HIGH_CYCLES - 1);
    localparam logic [PH_W-1:0] LO_LAST = PH_W'(LOW_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PH_W-1:0]      phase;
    logic [PH_W-1:0]      phase_nxt;
    logic [DIV_WIDTH-1:0] gap;
    logic [DIV_WIDTH-1:0] gap_nxt;
    logic [4:0]           remaining;
    logic [4:0]           remaining_nxt;
    logic [4:0]           burst_len;
    logic                 accept;
    logic                 bp_match;
    logic                 bp_stop;
    logic                 proc_clk_nxt;
    logic                 busy_nxt;
    logic                 step_inc;

    // A Burst field of zero encodes the maximum burst of 16 pulses.
    assign burst_len = (Burst == 4'd0) ? 5'd16 : {1'b0, Burst};

`ifdef STEP_BREAKPOINT_EN
    assign bp_match = BreakEn && (PC == BreakPC) && ((Mode == MODE_BURST) || (Mode == MODE_RUN));
`else
    assign bp_match = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            phase     <= '0;
            gap       <= '0;
            remaining <= '0;
            ProcClk   <= 1'b0;
            Busy      <= 1'b0;
            StepCount <= '0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            gap       <= gap_nxt;
            remaining <= remaining_nxt;
            ProcClk   <= proc_clk_nxt;
            Busy      <= busy_nxt;
            if (step_inc) begin
                StepCount <= StepCount + CNT_WIDTH'(1);
            end
        end
    end

`ifdef STEP_BREAKPOINT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            BreakHit <= 1'b0;
        end else if (accept) begin
            BreakHit <= 1'b0;
        end else if (bp_stop) begin
            BreakHit <= 1'b1;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        gap_nxt       = gap;
        remaining_nxt = remaining;
        accept        = 1'b0;
        bp_stop       = 1'b0;
        case (state)
            S_IDLE: begin
                phase_nxt = '0;
                if (!Halt && (Mode != MODE_HOLD) && Strobe) begin
                    accept    = 1'b1;
                    state_nxt = S_HI;
                    if (Mode == MODE_BURST) begin
                        remaining_nxt = burst_len - 5'd1;
                    end
                end
            end
            S_HI: begin
                if (phase == HI_LAST) begin
                    phase_nxt = '0;
                    state_nxt = S_LO;
                end else begin
                    phase_nxt = phase + PH_W'(1);
                end
            end
            S_LO: begin
                if (phase == LO_LAST) begin
                    phase_nxt = '0;
                    if (Halt) begin
                        state_nxt     = S_IDLE;
                        remaining_nxt = '0;
                    end else if (bp_match) begin
                        state_nxt     = S_IDLE;
                        remaining_nxt = '0;
                        bp_stop       = 1'b1;
                    end else if ((Mode == MODE_BURST) && (remaining != 5'd0)) begin
                        state_nxt     = S_HI;
                        remaining_nxt = remaining - 5'd1;
                    end else if ((Mode == MODE_RUN) && (RunDiv == '0)) begin
                        state_nxt = S_HI;
                    end else if (Mode == MODE_RUN) begin
                        state_nxt = S_GAP;
                        gap_nxt   = RunDiv;
                    end else begin
                        state_nxt     = S_IDLE;
                        remaining_nxt = '0;
                    end
                end else begin
                    phase_nxt = phase + PH_W'(1);
                end
            end
            S_GAP: begin
                if ((Mode != MODE_RUN) || Halt) begin
                    state_nxt     = S_IDLE;
                    gap_nxt       = '0;
                    remaining_nxt = '0;
                end else begin
                    gap_nxt = gap - DIV_WIDTH'(1);
                    if (gap == DIV_WIDTH'(1)) begin
                        state_nxt = S_HI;
                    end
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                phase_nxt     = '0;
                gap_nxt       = '0;
                remaining_nxt = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so ProcClk tracks HI exactly.
    always_comb begin
        proc_clk_nxt = (state_nxt == S_HI);
        busy_nxt     = (state_nxt != S_IDLE);
        step_inc     = (state_nxt == S_HI) && (state != S_HI);
    end

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Directed bench for step_clock_ctrl: single, burst, run, halt, dropped strobe, reset and optional breakpoint.
module tb_step_clock_ctrl;

    logic        Clock;
    logic        Reset;
    logic        Strobe;
    logic [1:0]  Mode;
    logic [3:0]  Burst;
    logic [23:0] RunDiv;
    logic        Halt;
    logic        ProcClk;
    logic        Busy;
    logic [15:0] StepCount;
`ifdef STEP_BREAKPOINT_EN
    logic [6:0]  PC;
    logic [6:0]  BreakPC;
    logic        BreakEn;
    logic        BreakHit;
`endif

    int total = 0;
    int bad   = 0;
    logic [255:0] cap_p;
    logic [255:0] cap_b;

    step_clock_ctrl #(
        .HIGH_CYCLES(4),
        .LOW_CYCLES (4),
        .DIV_WIDTH  (24),
        .CNT_WIDTH  (16)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Strobe   (Strobe),
        .Mode     (Mode),
        .Burst    (Burst),
        .RunDiv   (RunDiv),
        .Halt     (Halt),
`ifdef STEP_BREAKPOINT_EN
        .PC       (PC),
        .BreakPC  (BreakPC),
        .BreakEn  (BreakEn),
        .BreakHit (BreakHit),
`endif
        .ProcClk  (ProcClk),
        .Busy     (Busy),
        .StepCount(StepCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    // Strobe is sampled on the next edge; afterwards we sit at cycle 1.
    task automatic fire_strobe();
        Strobe = 1'b1;
        tick();
        Strobe = 1'b0;
    endtask

    task automatic capture(input int n);
        cap_p = '0;
        cap_b = '0;
        for (int k = 1; k <= n; k++) begin
            cap_p[k] = ProcClk;
            cap_b[k] = Busy;
            tick();
        end
    endtask

    // n pulses of 4 high / 4 low separated by gap idle cycles, first high at cycle 1.
    function automatic logic [255:0] pclk_pat(input int n, input int gap);
        logic [255:0] v;
        v = '0;
        for (int p = 0; p < n; p++)
            for (int h = 0; h < 4; h++)
                v[1 + p * (8 + gap) + h] = 1'b1;
        return v;
    endfunction

    function automatic logic [255:0] busy_pat(input int n, input int gap);
        logic [255:0] v;
        v = '0;
        for (int k = 1; k <= n * 8 + (n - 1) * gap; k++)
            v[k] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        total++; if (ProcClk !== 1'b0) begin bad++; $display("FAIL reset_pclk got=%b want=0", ProcClk); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", Busy); end
        total++; if (StepCount !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", StepCount); end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        Mode = 2'b00;
        fire_strobe();
        capture(12);
        total++; if (cap_p !== pclk_pat(1, 0)) begin bad++; $display("FAIL single_pclk got=%h want=%h", cap_p, pclk_pat(1, 0)); end
        total++; if (cap_b !== busy_pat(1, 0)) begin bad++; $display("FAIL single_busy got=%h want=%h", cap_b, busy_pat(1, 0)); end
        total++; if (StepCount !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", StepCount); end
    endtask

    task automatic test_burst();
        do_reset();
        Mode  = 2'b01;
        Burst = 4'd3;
        fire_strobe();
        capture(30);
        total++; if (cap_p !== pclk_pat(3, 0)) begin bad++; $display("FAIL burst3_pclk got=%h want=%h", cap_p, pclk_pat(3, 0)); end
        total++; if (cap_b !== busy_pat(3, 0)) begin bad++; $display("FAIL burst3_busy got=%h want=%h", cap_b, busy_pat(3, 0)); end
        total++; if (StepCount !== 16'd3) begin bad++; $display("FAIL burst3_count got=%0d want=3", StepCount); end
        Burst = 4'd0;
        fire_strobe();
        capture(140);
        total++; if (cap_p !== pclk_pat(16, 0)) begin bad++; $display("FAIL burst16_pclk got=%h want=%h", cap_p, pclk_pat(16, 0)); end
        total++; if (cap_b !== busy_pat(16, 0)) begin bad++; $display("FAIL burst16_busy got=%h want=%h", cap_b, busy_pat(16, 0)); end
        total++; if (StepCount !== 16'd19) begin bad++; $display("FAIL burst16_count got=%0d want=19", StepCount); end
    endtask

    task automatic test_run();
        do_reset();
        Mode   = 2'b10;
        RunDiv = 24'd5;
        fire_strobe();
        // Pulses start at 1, 14, 27; cycle 35 is the first cycle of the third gap.
        capture(34);
        total++; if (cap_p !== pclk_pat(3, 5)) begin bad++; $display("FAIL run_pclk got=%h want=%h", cap_p, pclk_pat(3, 5)); end
        total++; if (cap_b !== busy_pat(3, 5)) begin bad++; $display("FAIL run_busy got=%h want=%h", cap_b, busy_pat(3, 5)); end
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL run_in_gap got=%b want=1", Busy); end
        Mode = 2'b00;
        tick();
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL run_gap_exit got=%b want=0", Busy); end
        total++; if (StepCount !== 16'd3) begin bad++; $display("FAIL run_count got=%0d want=3", StepCount); end

        Mode = 2'b10;
        fire_strobe();
        Mode = 2'b00;
        capture(12);
        total++; if (cap_p !== pclk_pat(1, 0)) begin bad++; $display("FAIL run_hi_exit_pclk got=%h want=%h", cap_p, pclk_pat(1, 0)); end
        total++; if (cap_b !== busy_pat(1, 0)) begin bad++; $display("FAIL run_hi_exit_busy got=%h want=%h", cap_b, busy_pat(1, 0)); end
        total++; if (StepCount !== 16'd4) begin bad++; $display("FAIL run_hi_exit_count got=%0d want=4", StepCount); end
    endtask

    task automatic test_halt();
        do_reset();
        Mode  = 2'b01;
        Burst = 4'd5;
        fire_strobe();
        cap_p = '0;
        cap_b = '0;
        for (int k = 1; k <= 20; k++) begin
            Halt     = (k >= 10);
            cap_p[k] = ProcClk;
            cap_b[k] = Busy;
            tick();
        end
        total++; if (cap_p !== pclk_pat(2, 0)) begin bad++; $display("FAIL halt_pclk got=%h want=%h", cap_p, pclk_pat(2, 0)); end
        total++; if (cap_b !== busy_pat(2, 0)) begin bad++; $display("FAIL halt_busy got=%h want=%h", cap_b, busy_pat(2, 0)); end
        total++; if (StepCount !== 16'd2) begin bad++; $display("FAIL halt_count got=%0d want=2", StepCount); end
        fire_strobe();
        capture(10);
        total++; if ((cap_p | cap_b) !== 256'd0) begin bad++; $display("FAIL halt_blocks got=%h want=0", cap_p | cap_b); end
        total++; if (StepCount !== 16'd2) begin bad++; $display("FAIL halt_blocks_count got=%0d want=2", StepCount); end
        Halt = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        Mode = 2'b00;
        fire_strobe();
        cap_p = '0;
        cap_b = '0;
        for (int k = 1; k <= 12; k++) begin
            Strobe   = (k == 2);
            cap_p[k] = ProcClk;
            cap_b[k] = Busy;
            tick();
        end
        Strobe = 1'b0;
        total++; if (cap_p !== pclk_pat(1, 0)) begin bad++; $display("FAIL drop_pclk got=%h want=%h", cap_p, pclk_pat(1, 0)); end
        total++; if (StepCount !== 16'd1) begin bad++; $display("FAIL drop_count got=%0d want=1", StepCount); end

        fire_strobe();
        tick();
        total++; if (ProcClk !== 1'b1) begin bad++; $display("FAIL pre_reset_pclk got=%b want=1", ProcClk); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        total++; if (ProcClk !== 1'b0) begin bad++; $display("FAIL midhi_reset_pclk got=%b want=0", ProcClk); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL midhi_reset_busy got=%b want=0", Busy); end
        total++; if (StepCount !== 16'd0) begin bad++; $display("FAIL midhi_reset_count got=%0d want=0", StepCount); end
    endtask

`ifdef STEP_BREAKPOINT_EN
    task automatic test_breakpoint();
        do_reset();
        BreakEn = 1'b1;
        BreakPC = 7'h03;
        Mode    = 2'b10;
        RunDiv  = 24'd0;
        PC      = 7'd1;
        fire_strobe();
        cap_p = '0;
        cap_b = '0;
        for (int k = 1; k <= 32; k++) begin
            PC       = 7'((k - 1) / 8 + 1);
            cap_p[k] = ProcClk;
            cap_b[k] = Busy;
            tick();
        end
        total++; if (cap_p !== pclk_pat(3, 0)) begin bad++; $display("FAIL bp_pclk got=%h want=%h", cap_p, pclk_pat(3, 0)); end
        total++; if (cap_b !== busy_pat(3, 0)) begin bad++; $display("FAIL bp_busy got=%h want=%h", cap_b, busy_pat(3, 0)); end
        total++; if (BreakHit !== 1'b1) begin bad++; $display("FAIL bp_hit got=%b want=1", BreakHit); end
        total++; if (StepCount !== 16'd3) begin bad++; $display("FAIL bp_count got=%0d want=3", StepCount); end
        PC = 7'd1;
        fire_strobe();
        total++; if (BreakHit !== 1'b0) begin bad++; $display("FAIL bp_clear got=%b want=0", BreakHit); end
        total++; if (ProcClk !== 1'b1) begin bad++; $display("FAIL bp_restart got=%b want=1", ProcClk); end
        Mode = 2'b00;
        capture(10);
        BreakEn = 1'b0;
    endtask
`endif

    initial begin
        Reset  = 1'b1;
        Strobe = 1'b0;
        Mode   = 2'b00;
        Burst  = 4'd0;
        RunDiv = 24'd0;
        Halt   = 1'b0;
`ifdef STEP_BREAKPOINT_EN
        PC      = 7'd0;
        BreakPC = 7'd0;
        BreakEn = 1'b0;
`endif
        test_reset();
        test_single();
        test_burst();
        test_run();
        test_halt();
        test_back_to_back();
`ifdef STEP_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
